// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the accumulator-style core: steps each
// instruction through FETCH / EXEC / MEM / WB and issues phase-qualified controls.
module ctrl_sequencer #(
    parameter int OPW     = 3,
    parameter int SELW    = 3,
    parameter int MEM_LAT = 2,
    parameter int CNTW    = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            Halt_req,
    input  logic [OPW-1:0]  Instr,
    input  logic [SELW-1:0] TypeSel,
    input  logic            BrTaken,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCSrc,
    output logic            RegDst,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic            RegtoReg,
    output logic            SinChange,
    output logic            Busy,
    output logic            Done,
    output logic [CNTW-1:0] InstCount
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam logic [2:0] OP_RXOR  = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_MEM   = 3'b010;
    localparam logic [2:0] OP_BNEQ  = 3'b011;
    localparam logic [2:0] OP_HSET  = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_BLT   = 3'b110;

    // The counter is preloaded with MEM_LAT-1 so it reads zero in the last MEM cycle.
    localparam logic [3:0] MEM_INIT = 4'(MEM_LAT - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        wait_cnt_r;
    logic [CNTW-1:0]   inst_count_r;

    logic [2:0]        op_s;
    logic              nop_s;
    logic              is_alu_s;
    logic              is_shift_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              is_move_s;
    logic              is_branch_s;
    logic              sin_mode_s;
    logic              mem_first_s;
    logic              mem_last_s;
    logic              cnt_load_s;
    logic              cnt_clr_s;

    // Opcode/sub-op classification from the IR fields.
    always_comb begin
        op_s        = Instr[2:0];
        nop_s       = ((Instr >> 2'd3) != {OPW{1'b0}});
        is_alu_s    = !nop_s && ((op_s == OP_RXOR) || (op_s == OP_HSET) || (op_s == OP_AND));
        is_shift_s  = !nop_s && (op_s == OP_SHIFT);
        is_load_s   = !nop_s && (op_s == OP_MEM) && (TypeSel[1:0] == 2'b00);
        is_store_s  = !nop_s && (op_s == OP_MEM) && (TypeSel[1:0] == 2'b01);
        is_move_s   = !nop_s && (op_s == OP_MEM) && TypeSel[1];
        is_branch_s = !nop_s && ((op_s == OP_BNEQ) || (op_s == OP_BLT));
        sin_mode_s  = (TypeSel == SELW'(3'd4)) || (TypeSel == SELW'(3'd5));
        mem_first_s = (wait_cnt_r == MEM_INIT);
        mem_last_s  = (wait_cnt_r == 4'd0);
    end

    // Next-state and phase-qualified control outputs.
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_clr_s   = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        RegDst      = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegtoReg    = 1'b0;
        SinChange   = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt_s = ST_FETCH;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                Busy        = 1'b1;
                IRWrite     = 1'b1;
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                Busy = 1'b1;
                if (is_load_s || is_store_s) begin
                    cnt_load_s  = 1'b1;
                    state_nxt_s = ST_MEM;
                end else if (is_alu_s || is_shift_s || is_move_s) begin
                    state_nxt_s = ST_WB;
                end else begin
                    // Branches and no-ops retire straight out of EXEC.
                    PCWrite     = 1'b1;
                    PCSrc       = is_branch_s ? BrTaken : 1'b0;
                    state_nxt_s = Halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_MEM: begin
                Busy = 1'b1;
                if (is_store_s) begin
                    MemWrite = mem_first_s;
                    if (mem_last_s) begin
                        PCWrite     = 1'b1;
                        state_nxt_s = Halt_req ? ST_HALT : ST_FETCH;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end else begin
                    MemtoReg = 1'b1;
                    RegDst   = 1'b1;
                    if (mem_last_s) begin
                        state_nxt_s = ST_WB;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end
            end
            ST_WB: begin
                Busy        = 1'b1;
                RegWrite    = 1'b1;
                PCWrite     = 1'b1;
                RegDst      = is_shift_s || is_load_s || (is_move_s && TypeSel[0]);
                MemtoReg    = is_load_s;
                RegtoReg    = is_move_s;
                SinChange   = is_shift_s && sin_mode_s;
                state_nxt_s = Halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                Done = 1'b1;
                if (Start) begin
                    state_nxt_s = ST_FETCH;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory wait counter: loaded in EXEC, counts down while in MEM.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt_r <= 4'd0;
        end else if (cnt_load_s) begin
            wait_cnt_r <= MEM_INIT;
        end else if ((state_r == ST_MEM) && !mem_last_s) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Saturating retired-instruction counter; PCWrite marks each retire.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            inst_count_r <= {CNTW{1'b0}};
        end else if (cnt_clr_s) begin
            inst_count_r <= {CNTW{1'b0}};
        end else if (PCWrite && (inst_count_r != {CNTW{1'b1}})) begin
            inst_count_r <= inst_count_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            inst_count_r <= inst_count_r;
        end
    end

    assign InstCount = inst_count_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed and random instruction streams
// compared cycle by cycle against a per-instruction expected-trace model.
module tb_ctrl_sequencer;

    localparam int OPW  = 4;
    localparam int SELW = 3;
    localparam int LAT  = 3;
    localparam int CNTW = 4;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic            Start;
    logic            Halt_req;
    logic [OPW-1:0]  Instr;
    logic [SELW-1:0] TypeSel;
    logic            BrTaken;
    logic            IRWrite, PCWrite, PCSrc, RegDst, MemWrite, RegWrite;
    logic            MemtoReg, RegtoReg, SinChange, Busy, Done;
    logic [CNTW-1:0] InstCount;

    ctrl_sequencer #(.OPW(OPW), .SELW(SELW), .MEM_LAT(LAT), .CNTW(CNTW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt_req(Halt_req),
        .Instr(Instr), .TypeSel(TypeSel), .BrTaken(BrTaken),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDst(RegDst),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .RegtoReg(RegtoReg), .SinChange(SinChange), .Busy(Busy), .Done(Done),
        .InstCount(InstCount)
    );

    always #5 Clk = ~Clk;

    wire [10:0] obs_vec = {IRWrite, PCWrite, PCSrc, RegDst, MemWrite, RegWrite,
                           MemtoReg, RegtoReg, SinChange, Busy, Done};

    int              n_pass  = 0;
    int              n_total = 0;
    logic [CNTW-1:0] model_cnt = '0;
    bit              halted = 1'b0;
    logic [10:0]     exp_q[$];

    function automatic logic [10:0] mk(input bit ir, input bit pcw, input bit pcs, input bit rd,
                                       input bit mw, input bit rw, input bit m2r, input bit r2r,
                                       input bit sin, input bit busy, input bit done);
        return {ir, pcw, pcs, rd, mw, rw, m2r, r2r, sin, busy, done};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected per-cycle output trace of one instruction, from the latency/control rules.
    task automatic build_trace(input logic [3:0] ins, input logic [2:0] sel, input logic br);
        bit nop, branch, memop, load, store, move, shift;
        nop    = ins[3] || (ins[2:0] == 3'b111);
        branch = !nop && ((ins[2:0] == 3'b011) || (ins[2:0] == 3'b110));
        memop  = !nop && (ins[2:0] == 3'b010);
        load   = memop && (sel[1:0] == 2'b00);
        store  = memop && (sel[1:0] == 2'b01);
        move   = memop && sel[1];
        shift  = !nop && (ins[2:0] == 3'b001);
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        if (nop || branch) begin
            exp_q.push_back(mk(1'b0, 1'b1, branch & br, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            if (load || store) begin
                for (int i = 0; i < LAT; i++) begin
                    if (store) exp_q.push_back(mk(1'b0, i == LAT-1, 1'b0, 1'b0, i == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                    else       exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
                end
            end
            if (!store) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, shift || load || (move && sel[0]), 1'b0, 1'b1,
                                   load, move, shift && ((sel == 3'd4) || (sel == 3'd5)), 1'b1, 1'b0));
            end
        end
    endtask

    // Entered at posedge+1 with FETCH as the coming state; leaves at posedge+1.
    task automatic run_instr(input logic [3:0] ins, input logic [2:0] sel, input logic br, input bit halt);
        int n;
        build_trace(ins, sel, br);
        n       = exp_q.size();
        Instr   = ins;
        TypeSel = sel;
        BrTaken = br;
        for (int i = 0; i < n; i++) begin
            Halt_req = (i == n-1) ? halt : 1'($urandom_range(0, 1));
            Start    = 1'($urandom_range(0, 1));
            @(negedge Clk);
            check($sformatf("outs i=%h s=%h c%0d", ins, sel, i), 16'(obs_vec), 16'(exp_q[i]));
            check("instcount", 16'(InstCount), 16'(model_cnt));
            @(posedge Clk); #1;
        end
        if (model_cnt != 4'hF) model_cnt++;
        halted = halt;
        Halt_req = 1'b0;
        Start    = 1'b0;
    endtask

    task automatic hold_idle(input int n);
        Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            Halt_req = 1'($urandom_range(0, 1));
            @(negedge Clk);
            check("idle outs", 16'(obs_vec), 16'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, halted)));
            check("idle instcount", 16'(InstCount), 16'(model_cnt));
            @(posedge Clk); #1;
        end
        Halt_req = 1'b0;
    endtask

    task automatic start_seq();
        Start    = 1'b1;
        Halt_req = 1'($urandom_range(0, 1));
        @(negedge Clk);
        check("start outs", 16'(obs_vec), 16'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, halted)));
        @(posedge Clk); #1;
        Start     = 1'b0;
        Halt_req  = 1'b0;
        model_cnt = '0;
        halted    = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] ri;
        logic [2:0] rs;
        Reset_n = 1'b0; Start = 1'b0; Halt_req = 1'b0;
        Instr = '0; TypeSel = '0; BrTaken = 1'b0;
        #1;
        check("reset outs", 16'(obs_vec), 16'h0000);
        check("reset instcount", 16'(InstCount), 16'h0000);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        hold_idle(3);

        // Directed: first five instructions, halt requested in WB of the fifth.
        start_seq();
        run_instr(4'b0000, 3'b000, 1'b0, 1'b0);
        run_instr(4'b0001, 3'b100, 1'b0, 1'b0);
        run_instr(4'b0010, 3'b100, 1'b0, 1'b0);
        run_instr(4'b0010, 3'b101, 1'b0, 1'b0);
        run_instr(4'b0001, 3'b010, 1'b0, 1'b1);
        hold_idle(2);
        check("halt count", 16'(InstCount), 16'd5);
        start_seq();
        check("count cleared", 16'(InstCount), 16'd0);

        // Directed: branches, no-ops, moves, remaining ALU ops.
        run_instr(4'b0011, 3'b000, 1'b1, 1'b0);
        run_instr(4'b0011, 3'b000, 1'b0, 1'b0);
        run_instr(4'b0110, 3'b011, 1'b1, 1'b0);
        run_instr(4'b0111, 3'b000, 1'b1, 1'b0);
        run_instr(4'b1010, 3'b000, 1'b1, 1'b0);
        run_instr(4'b0010, 3'b010, 1'b0, 1'b0);
        run_instr(4'b0010, 3'b111, 1'b0, 1'b0);
        run_instr(4'b0100, 3'b000, 1'b0, 1'b0);
        run_instr(4'b0101, 3'b101, 1'b0, 1'b0);
        run_instr(4'b0001, 3'b101, 1'b0, 1'b0);

        // Random run long enough to reach counter saturation.
        for (int k = 0; k < 12; k++) begin
            ri = {1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7))};
            rs = 3'($urandom_range(0, 7));
            run_instr(ri, rs, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("saturated", 16'(InstCount), 16'h000F);

        // Random run with occasional halts and restarts.
        for (int k = 0; k < 40; k++) begin
            ri = {1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7))};
            rs = 3'($urandom_range(0, 7));
            run_instr(ri, rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            if (halted) begin
                hold_idle(int'($urandom_range(1, 2)));
                start_seq();
            end
        end
        if (halted) start_seq();

        // Reset asserted in the second MEM cycle of a store.
        run_instr(4'b0000, 3'b000, 1'b0, 1'b0);
        Instr = 4'b0010; TypeSel = 3'b001; Halt_req = 1'b0; Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(negedge Clk);
        check("store mem1 strobe", 16'(MemWrite), 16'd1);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("midreset outs", 16'(obs_vec), 16'h0000);
        check("midreset instcount", 16'(InstCount), 16'h0000);
        model_cnt = '0;
        halted    = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        hold_idle(4);
        start_seq();
        run_instr(4'b0010, 3'b001, 1'b0, 1'b0);
        run_instr(4'b0010, 3'b000, 1'b0, 1'b1);
        hold_idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
